// File: rtl/apb_timer_pkg.sv
// rtl/apb_timer_pkg.sv - register map, CTRL field positions and FSM states for apb_timer
package apb_timer_pkg;

    localparam logic [3:0] ADDR_CTRL    = 4'h0;
    localparam logic [3:0] ADDR_COUNT   = 4'h4;
    localparam logic [3:0] ADDR_COMPARE = 4'h8;
    localparam logic [3:0] ADDR_STATUS  = 4'hC;

    localparam int CTRL_EN           = 0;
    localparam int CTRL_IE           = 1;
    localparam int CTRL_ONESHOT      = 2;
    localparam int CTRL_PRESCALE_LSB = 8;
    localparam int CTRL_PRESCALE_MSB = 15;

    // Only EN, IE, ONESHOT and PRESCALE are implemented; everything else reads 0.
    localparam logic [31:0] CTRL_MASK = 32'h0000_FF07;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } apb_state_e;

    function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  strb);
        logic [31:0] result;
        result = old_val;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) begin
                result[8*i +: 8] = wdata[8*i +: 8];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/apb_timer_prescaler.sv
// rtl/apb_timer_prescaler.sv - 8-bit prescaler producing a one-cycle tick every PRESCALE+1 enabled cycles
module apb_timer_prescaler
    import apb_timer_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] prescale,
    output logic       tick
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (!en) begin
            cnt_d = 8'h00;
        end else if (cnt_q == prescale) begin
            tick  = 1'b1;
            cnt_d = 8'h00;
        end else begin
            cnt_d = cnt_q + 8'h01;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 8'h00;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/apb_timer.sv
// rtl/apb_timer.sv - APB slave timer: CTRL/COUNT/COMPARE/STATUS registers, compare match and level IRQ
module apb_timer
    import apb_timer_pkg::*;
#(
    parameter int PADDR_SIZE = 10,
    parameter int PDATA_SIZE = 32
) (
    input  logic                    PRESETn,
    input  logic                    PCLK,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic [PADDR_SIZE-1:0]   PADDR,
    input  logic                    PWRITE,
    input  logic [PDATA_SIZE-1:0]   PWDATA,
    input  logic [PDATA_SIZE/8-1:0] PSTRB,
    input  logic [2:0]              PPROT,
    output logic [PDATA_SIZE-1:0]   PRDATA,
    output logic                    PREADY,
    output logic                    PSLVERR,
    output logic                    IRQ
);

    generate
        if (PDATA_SIZE != 32) begin : g_bad_pdata
            $error("apb_timer: PDATA_SIZE must be 32");
        end
        if (PADDR_SIZE < 4) begin : g_bad_paddr
            $error("apb_timer: PADDR_SIZE must be >= 4");
        end
    endgenerate

    logic unused_pprot;
    assign unused_pprot = ^PPROT;

    apb_state_e state_q, state_d;
    logic [31:0] ctrl_q, ctrl_d;
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        match_q, match_d;
    logic [PDATA_SIZE-1:0] prdata_q, prdata_d;
    logic        pready_q, pready_d;
    logic        pslverr_q, pslverr_d;
    logic        irq_q, irq_d;

    logic        tick;
    logic        hit;
    logic        access;
    logic        addr_err;
    logic        wr_ok;
    logic [3:0]  reg_sel;
    logic [PDATA_SIZE-1:0] rdata;

    apb_timer_prescaler u_prescaler (
        .clk      (PCLK),
        .rst_n    (PRESETn),
        .en       (ctrl_q[CTRL_EN]),
        .prescale (ctrl_q[CTRL_PRESCALE_MSB:CTRL_PRESCALE_LSB]),
        .tick     (tick)
    );

    always_comb begin
        access   = (state_q == ST_IDLE) && PSEL && PENABLE;
        addr_err = (PADDR[1:0] != 2'b00) || ((PADDR >> 4) != '0);
        reg_sel  = PADDR[3:0];
        wr_ok    = access && PWRITE && !addr_err;
        hit      = tick && (count_q == compare_q);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (PSEL && PENABLE) state_d = ST_RESP;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Ordering below encodes the race priorities: APB COUNT write over tick,
    // match set over STATUS clear, one-shot EN clear over an APB EN write.
    always_comb begin
        ctrl_d    = ctrl_q;
        count_d   = count_q;
        compare_d = compare_q;
        match_d   = match_q;

        if (tick) begin
            count_d = hit ? 32'h0 : count_q + 32'h1;
        end

        if (wr_ok) begin
            case (reg_sel)
                ADDR_CTRL:    ctrl_d    = apply_strb(ctrl_q, PWDATA, PSTRB) & CTRL_MASK;
                ADDR_COUNT:   count_d   = apply_strb(count_q, PWDATA, PSTRB);
                ADDR_COMPARE: compare_d = apply_strb(compare_q, PWDATA, PSTRB);
                ADDR_STATUS:  if (PSTRB[0] && PWDATA[0]) match_d = 1'b0;
                default: ;
            endcase
        end

        if (hit) begin
            match_d = 1'b1;
            if (ctrl_q[CTRL_ONESHOT]) begin
                ctrl_d[CTRL_EN] = 1'b0;
            end
        end
    end

    always_comb begin
        rdata = '0;
        case (reg_sel)
            ADDR_CTRL:    rdata = ctrl_q;
            ADDR_COUNT:   rdata = count_q;
            ADDR_COMPARE: rdata = compare_q;
            ADDR_STATUS:  rdata = {31'h0, match_q};
            default:      rdata = '0;
        endcase

        prdata_d = prdata_q;
        if (access && !PWRITE) begin
            prdata_d = addr_err ? '0 : rdata;
        end
        pready_d  = access;
        pslverr_d = access && addr_err;
        irq_d     = match_q && ctrl_q[CTRL_IE];
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q   <= ST_IDLE;
            ctrl_q    <= 32'h0;
            count_q   <= 32'h0;
            compare_q <= 32'h0;
            match_q   <= 1'b0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ctrl_q    <= ctrl_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            match_q   <= match_d;
            prdata_q  <= prdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            irq_q     <= irq_d;
        end
    end

    assign PRDATA  = prdata_q;
    assign PREADY  = pready_q;
    assign PSLVERR = pslverr_q;
    assign IRQ     = irq_q;

endmodule

// File: doc/apb_timer.md
APB_TIMER -- requirements
Module: apb_timer

Interface
REQ-001 Parameter PADDR_SIZE, default 10: APB address width; must be >= 4.
REQ-002 Parameter PDATA_SIZE, default 32: APB data width; only 32 is supported, and an elaboration-time assertion flags any other value.
REQ-003 PRESETn  in  1  asynchronous active-low reset.
REQ-004 PCLK  in  1  the single clock; all state changes on its rising edge.
REQ-005 PSEL  in  1  slave select.
REQ-006 PENABLE  in  1  access phase.
REQ-007 PADDR  in  PADDR_SIZE  byte address.
REQ-008 PWRITE  in  1  1 = write.
REQ-009 PWDATA  in  PDATA_SIZE  write data.
REQ-010 PSTRB  in  PDATA_SIZE/8  byte write enables.
REQ-011 PPROT  in  3  accepted and ignored.
REQ-012 PRDATA  out  PDATA_SIZE  read data, registered.
REQ-013 PREADY  out  1  transfer complete, registered.
REQ-014 PSLVERR  out  1  error response, qualified by PREADY.
REQ-015 IRQ  out  1  level interrupt, registered.

Function
REQ-016 Register map (byte offsets):
- 0x0 CTRL: bit0 EN, bit1 IE, bit2 ONESHOT, bits[15:8] PRESCALE; all other bits read 0.
- 0x4 COUNT: 32-bit, read/write.
- 0x8 COMPARE: 32-bit, read/write.
- 0xC STATUS: bit0 MATCH; writing 1 clears it; other bits read 0.
REQ-017 Handshake FSM states:
- ST_IDLE: PREADY=0.
- ST_IDLE to ST_RESP: on PSEL&PENABLE.
- ST_RESP: PREADY=1.
- ST_RESP to ST_IDLE: unconditionally.
- Every access therefore has exactly one wait state.
REQ-018 Write commit: a write takes effect on the ST_IDLE to ST_RESP edge, per byte where PSTRB is 1.
REQ-019 Read capture: PRDATA is loaded on the same edge, and holds its value otherwise.
REQ-020 Error decode:
- PSLVERR is set when PADDR[1:0]!=0 or PADDR[PADDR_SIZE-1:4]!=0.
- An erroneous write has no side effect.
- An erroneous read returns PRDATA=0.
REQ-021 Prescaler: an 8-bit counter increments every PCLK while EN=1. When it equals PRESCALE it produces a one-cycle tick and wraps to 0. With PRESCALE=0, a tick occurs every cycle.
REQ-022 On a tick, COUNT increments modulo 2^32 (0xFFFFFFFF wraps to 0).
REQ-023 Match: when a tick occurs with COUNT==COMPARE:
- COUNT is loaded with 0 instead of incrementing.
- MATCH is set.
- If ONESHOT=1, EN is cleared.
REQ-024 IRQ is registered MATCH&IE, so it lags MATCH by one cycle.
REQ-025 Clearing EN resets the prescaler counter to 0; COUNT holds its value.
REQ-026 Simultaneous events:
- An APB write to COUNT in a tick cycle: the write wins.
- A STATUS write-1-clear in a match cycle: the set wins.
- An APB write setting EN in the cycle a ONESHOT match clears EN: the match clear wins.

Reset
REQ-027 While PRESETn=0, all of the following are 0: PRDATA, PREADY, PSLVERR, IRQ, CTRL, COUNT, COMPARE, MATCH, the prescaler counter; the FSM is in ST_IDLE.
REQ-028 Reset asserted mid-transfer aborts the transfer. No partial write persists beyond the reset values.
REQ-029 After deassertion, the first transfer behaves exactly as REQ-017.

Structure
REQ-030 Package apb_timer_pkg holds:
- the register offset constants;
- the CTRL bit-position constants;
- the FSM state typedef.
REQ-031 Sub-module apb_timer_prescaler holds the prescaler counter and tick logic. Inputs: EN, PRESCALE. Output: tick.
REQ-032 Register bank, decode and FSM stay in apb_timer.

Verification
REQ-033 Read after reset: read 0x4 -> PREADY high exactly one cycle after the access phase starts; PRDATA=0, PSLVERR=0.
REQ-034 Match, prescaled: write COMPARE=3 and CTRL=0x0000_0403 (PRESCALE=4, IE, EN) ->
- COUNT increments every 5 cycles;
- MATCH sets and COUNT returns to 0 on the 4th tick;
- IRQ rises one cycle later.
REQ-035 One-shot and clear: write CTRL=0x7 with COMPARE=0 ->
- MATCH and EN=0 after the first tick;
- write STATUS=0x1 -> MATCH=0 and IRQ=0 one cycle later.
REQ-036 Errors: write 0x10 and write 0x6 ->
- PSLVERR=1 with PREADY;
- no register changes;
- a read of 0x10 returns 0 with PSLVERR=1.
REQ-037 Byte strobes: write 0x8 with PWDATA=0xAABBCCDD, PSTRB=0b0101 over COMPARE=0 -> read 0x8 returns 0x00BB00DD.
REQ-038 Races and reset:
- write COUNT=0x100 in a tick cycle -> COUNT=0x100;
- COUNT=0xFFFFFFFF with COMPARE=0x10 -> next tick gives COUNT=0;
- PRESETn pulsed mid-access -> PREADY=0 and all registers at reset values.
